// File: rtl/mul4_seq_if.sv
// mul4_seq_if -- request/response bundle between the ALU control and the
// sequential 4x4 multiplier.
//
// Signals:
//   start  request; the multiplier samples it only while accepting (IDLE/DONE)
//   A, B   4-bit unsigned operands, captured on an accepted start
//   P      8-bit product, valid while done=1, held until the next result
//   busy   high while the multiplier is iterating
//   done   single-cycle pulse marking a fresh product on P
//
// Handshake: the requester raises start with A/B stable across a rising edge.
// If the multiplier is in IDLE or DONE at that edge, the request is accepted and the
// operands are captured. From then on, start, A and B are ignored until done
// pulses. A start held high through the done cycle is accepted again on the
// next edge, which gives back-to-back operation.
//
// Modports:
//   master  the requester (drives start/A/B, observes P/busy/done)
//   slave   the multiplier
interface mul4_seq_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] P;
  logic       busy;
  logic       done;

  modport master (output start, output A, output B,
                  input  P, input busy, input done);
  modport slave  (input  start, input A, input B,
                  output P, output busy, output done);
endinterface

// File: rtl/mul4_seq.sv
// mul4_seq -- sequential 4x4 unsigned shift-and-add multiplier, 8-bit product.
//
// A single 4-bit ripple adder (sum4) is the only arithmetic element. It is
// reused once per iteration across four CALC cycles. The adder carry shifts
// into ACC[3], so every product up to 15*15 = 8'hE1 fits without overflow.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (wins in every state)
//   bus        mul4_seq_if.slave: start, A, B in; P, busy, done out
//   dbg_state  current FSM state (0=IDLE, 1=CALC, 2=DONE)
//
// Timing: if start is accepted at edge k, busy is high after edges k..k+3
// and done is high for one cycle after edge k+4. With start held high, the
// multiplier produces one product every 5 clocks.
//
// Optional build macro: MUL4_ZERO_SKIP_EN
//   When this macro is defined, an accepted start with A==0 or B==0 bypasses
//   CALC. P is loaded with 8'h00 and done rises right after the accepting
//   edge, and busy never asserts. When it is not defined, zero operands run
//   the full four iterations like any other operands.

// 4-bit ripple-carry adder built from a chain of full adders.
module sum4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [4:0] c;

  always_comb begin
    c     = '0;
    s     = '0;
    c[0]  = c_in;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c_out = c[4];
  end
endmodule

module mul4_seq (
  input  logic           clk,
  input  logic           reset,
  mul4_seq_if.slave      bus,
  output logic [1:0]     dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] m_reg;    // multiplicand
  logic [3:0] q_reg;    // multiplier, fills with the low product bits
  logic [3:0] acc_reg;  // high product bits
  logic [1:0] cnt;
  logic [7:0] p_reg;
  logic       busy_reg;
  logic       done_reg;

  logic [3:0] addend;
  logic [3:0] sum;
  logic       carry;
  logic [3:0] acc_next;
  logic [3:0] q_next;
  logic       skip;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign addend = q_reg[0] ? m_reg : 4'h0;

  sum4 u_sum4 (
    .a     (acc_reg),
    .b     (addend),
    .c_in  (1'b0),
    .s     (sum),
    .c_out (carry)
  );

  // Shift {carry, sum, Q} right by one. The carry becomes the new ACC MSB,
  // and the bit shifted out of sum moves into the top of Q.
  assign acc_next = {carry, sum[3:1]};
  assign q_next   = {sum[0], q_reg[3:1]};

`ifdef MUL4_ZERO_SKIP_EN
  assign skip = (bus.A == 4'h0) || (bus.B == 4'h0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      m_reg    <= 4'h0;
      q_reg    <= 4'h0;
      acc_reg  <= 4'h0;
      cnt      <= 2'd0;
      p_reg    <= 8'h00;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (skip) begin
              // A zero operand forces a zero product, so the iterations can be skipped.
              p_reg    <= 8'h00;
              state    <= S_DONE;
              busy_reg <= 1'b0;
              done_reg <= 1'b1;
            end else begin
              m_reg    <= bus.A;
              q_reg    <= bus.B;
              acc_reg  <= 4'h0;
              cnt      <= 2'd0;
              state    <= S_CALC;
              busy_reg <= 1'b1;
              done_reg <= 1'b0;
            end
          end else begin
            state    <= S_IDLE;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
          end
        end

        S_CALC: begin
          acc_reg <= acc_next;
          q_reg   <= q_next;
          cnt     <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            p_reg    <= {acc_next, q_next};
            state    <= S_DONE;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.P     = p_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign dbg_state = state;
endmodule

// File: tb/tb_mul4_seq.sv
// tb_mul4_seq -- directed-vector bench for mul4_seq with hand-computed products.
module tb_mul4_seq;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  mul4_seq_if bus ();

  mul4_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  // Inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One operation from IDLE/DONE. If inject is set, a second request (1*1)
  // is pulsed so that it is sampled at edge k+2, while the operation is in CALC.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input bit inject, input string tag);
    bit zs;
    logic [7:0] want;
    zs = 1'b0;
`ifdef MUL4_ZERO_SKIP_EN
    zs = (a == 4'h0) || (b == 4'h0);
`endif
    exp_q.push_back(exp);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    tick();                      // edge k
    bus.start = 1'b0;
    if (!zs) begin
      for (int i = 0; i < 4; i++) begin
        check({tag, "_busy"}, {7'd0, bus.busy}, 8'd1);
        check({tag, "_nodone"}, {7'd0, bus.done}, 8'd0);
        if (inject && i == 1) begin
          bus.A = 4'd1;
          bus.B = 4'd1;
          bus.start = 1'b1;
        end
        if (inject && i == 2) bus.start = 1'b0;
        tick();
      end
    end
    // Here the edge just passed is k+4, or k when a zero skip applies.
    want = exp_q.pop_front();
    check({tag, "_done"}, {7'd0, bus.done}, 8'd1);
    check({tag, "_busy_low"}, {7'd0, bus.busy}, 8'd0);
    check({tag, "_state_done"}, {6'd0, dbg_state}, 8'd2);
    check({tag, "_P"}, bus.P, want);
    tick();
    check({tag, "_pulse"}, {7'd0, bus.done}, 8'd0);
    check({tag, "_P_hold"}, bus.P, want);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.A = 4'h0;
    bus.B = 4'h0;
    reset = 1'b1;
    @(negedge clk);
    tick();
    tick();
    check("rst_P", bus.P, 8'h00);
    check("rst_busy", {7'd0, bus.busy}, 8'd0);
    check("rst_done", {7'd0, bus.done}, 8'd0);
    check("rst_state", {6'd0, dbg_state}, 8'd0);
    reset = 1'b0;
    tick();

    // Basic product, then the carry path and a power-of-two case.
    run_op(4'd3, 4'd5, 8'h0F, 1'b0, "t1_3x5");
    run_op(4'd15, 4'd15, 8'hE1, 1'b0, "t2_15x15");
    run_op(4'd8, 4'd2, 8'h10, 1'b0, "t2_8x2");
    for (int i = 0; i < 3; i++) tick();
    check("t2_idle_hold", bus.P, 8'h10);
    check("t2_idle_state", {6'd0, dbg_state}, 8'd0);

    // A start pulsed during CALC must be ignored.
    run_op(4'd6, 4'd7, 8'h2A, 1'b1, "t3_6x7");
    tick();
    check("t3_no_extra_busy", {7'd0, bus.busy}, 8'd0);
    check("t3_no_extra_done", {7'd0, bus.done}, 8'd0);

    // With start held high, a product is done every 5 clocks.
    bus.A = 4'd2;
    bus.B = 4'd3;
    bus.start = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      check($sformatf("t4_busy_%0d", t), {7'd0, bus.busy}, (t % 5 < 4) ? 8'd1 : 8'd0);
      check($sformatf("t4_done_%0d", t), {7'd0, bus.done}, (t % 5 == 4) ? 8'd1 : 8'd0);
      if (t % 5 == 4) check($sformatf("t4_P_%0d", t), bus.P, 8'h06);
    end
    bus.start = 1'b0;
    tick();
    check("t4_stop_done", {7'd0, bus.done}, 8'd0);
    check("t4_stop_state", {6'd0, dbg_state}, 8'd0);

    // A reset during CALC aborts the operation, and no done pulse follows.
    bus.A = 4'd9;
    bus.B = 4'd9;
    bus.start = 1'b1;
    tick();                      // edge k
    bus.start = 1'b0;
    tick();                      // edge k+1
    reset = 1'b1;
    tick();                      // edge k+2 applies the reset
    check("t5_P", bus.P, 8'h00);
    check("t5_busy", {7'd0, bus.busy}, 8'd0);
    check("t5_done", {7'd0, bus.done}, 8'd0);
    check("t5_state", {6'd0, dbg_state}, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t5_quiet_%0d", i), {7'd0, bus.done}, 8'd0);
    end
    run_op(4'd4, 4'd5, 8'h14, 1'b0, "t5_4x5");

    // Zero operands (the latency depends on MUL4_ZERO_SKIP_EN).
    run_op(4'd0, 4'd9, 8'h00, 1'b0, "t6_0x9");
    run_op(4'd13, 4'd11, 8'h8F, 1'b0, "t6_13x11");
    run_op(4'd5, 4'd0, 8'h00, 1'b0, "t6_5x0");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
